// File: rtl/color_fifo_if.sv
// Handshake bundle for color_fifo: producer side, consumer side, channel
// swap control and fill level. The master modport is the environment that
// feeds and drains the FIFO; the slave modport is the FIFO itself.
interface color_fifo_if #(
  parameter int CH    = 3,
  parameter int DW    = 8,
  parameter int DEPTH = 4
);
  localparam int WW = CH * DW;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_data;
  logic          swap;
  logic [CW-1:0] count;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    output swap,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  count
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    input  swap,
    output in_ready,
    output out_valid,
    output out_data,
    output count
  );
endinterface

// File: rtl/color_fifo.sv
// color_fifo: synchronous FIFO of packed multi-channel pixel words.
// Words are stored untouched; the optional channel reversal is applied
// combinationally on the read side, so toggling swap never disturbs storage.
// Ready/valid are derived from registered state only, and an empty FIFO never
// falls a word through in the same cycle it is written.
module color_fifo #(
  parameter int CH    = 3,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  color_fifo_if.slave bus
);
  localparam int WW = CH * DW;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};

  // Reverse channel order: output channel k takes stored channel CH-1-k.
  function automatic logic [WW-1:0] swap_channels(input logic [WW-1:0] word);
    logic [WW-1:0] res;
    res = {WW{1'b0}};
    for (int k = 0; k < CH; k++) begin
      res[k*DW +: DW] = word[(CH-1-k)*DW +: DW];
    end
    return res;
  endfunction

  logic [WW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  logic          full_s;
  logic          empty_s;
  logic          in_ready_s;
  logic          out_valid_s;
  logic          push_s;
  logic          pop_s;
  logic [WW-1:0] head_s;
  logic [WW-1:0] out_data_s;

  // Flow-control flags from the registered fill level only.
  always_comb begin
    full_s      = (count_r == DEPTH_C);
    empty_s     = (count_r == ZERO_C);
    in_ready_s  = !rst && !full_s;
    out_valid_s = !rst && !empty_s;
    push_s      = bus.in_valid && in_ready_s;
    pop_s       = out_valid_s && bus.out_ready;
  end

  // Read-side data path: oldest word, optionally channel-reversed.
  always_comb begin
    head_s = mem_r[rd_ptr_r];
    if (bus.swap) begin
      out_data_s = swap_channels(head_s);
    end else begin
      out_data_s = head_s;
    end
  end

  // Pointer and fill-level bookkeeping; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= ZERO_C;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array: written on accepted pushes only, needs no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.in_data;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = out_data_s;
  assign bus.count     = count_r;
endmodule

// File: doc/color_fifo.md
COLOR_FIFO -- requirements
Module: color_fifo

Interface
REQ-001 Parameter CH, default 3, number of colour channels per pixel word.
REQ-002 Parameter DW, default 8, bits per channel.
REQ-003 Parameter DEPTH, default 4, pixel words stored; power of two, >= 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 in_valid  input  1  producer offers in_data.
REQ-007 in_ready  output  1  FIFO accepts a word this cycle.
REQ-008 in_data  input  CH*DW  packed pixel; channel 0 in MSBs (r,g,b order for CH=3).
REQ-009 out_valid  output  1  out_data holds the oldest stored word.
REQ-010 out_ready  input  1  consumer takes out_data this cycle.
REQ-011 out_data  output  CH*DW  packed pixel, same channel order as in_data unless swapped.
REQ-012 swap  input  1  1 = output channel order reversed (channel CH-1 in MSBs).
REQ-013 count  output  $clog2(DEPTH)+1  number of words stored.

Function
REQ-014 Push occurs when in_valid && in_ready at a rising edge; word written at write pointer, pointer advances.
REQ-015 Pop occurs when out_valid && out_ready at a rising edge; read pointer advances.
REQ-016 in_ready = !rst && (count < DEPTH); combinational from registered state only, never from in_valid or out_ready.
REQ-017 out_valid = (count != 0); registered-state only, no combinational path from in_valid.
REQ-018 Latency: word pushed at edge N appears at out_data with out_valid=1 after edge N (no same-cycle fall-through when empty).
REQ-019 Ordering strictly first-in first-out; no word dropped, duplicated or reordered.
REQ-020 count update: push only +1, pop only -1, push and pop together unchanged.
REQ-021 Simultaneous push and pop allowed whenever 0 < count < DEPTH; both take effect same edge.
REQ-022 Full (count=DEPTH): in_ready=0; a pop that edge frees one slot, in_ready=1 the following cycle.
REQ-023 Empty (count=0): out_valid=0; out_ready ignored; out_data value don't-care.
REQ-024 Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 without stall or gap.
REQ-025 swap is combinational on out_data: output channel k = stored channel CH-1-k; storage unaffected; may change any cycle.
REQ-026 in_data channels are never altered in storage; width exactly CH*DW, no truncation or extension.
REQ-027 out_data stable while out_valid=1 and out_ready=0 (given constant swap).

Reset
REQ-028 rst sampled at rising edge; while asserted: count=0, both pointers=0, out_valid=0, in_ready=0.
REQ-029 Reset mid-operation discards all stored words; push/pop coinciding with reset edge ignored.
REQ-030 First edge after rst deasserts: in_ready=1, out_valid=0; storage array needs no reset.

Verification
REQ-031 Reset then push 0x010203, 0x040506 with out_ready=0 -> count=2, out_valid=1, out_data=0x010203, in_ready=1.
REQ-032 Push 0x000000..0x030303 (4 words) with out_ready=0 -> count=4, in_ready=0; fifth word held by producer not accepted; pop once -> next cycle in_ready=1, count=3.
REQ-033 Stream 0x000000..0x0F0F0F (i replicated per channel) with in_valid=out_ready=1 constant -> out_data sequence identical, one word per cycle after first, count stays 1, pointers wrap 4 times.
REQ-034 Store 0x112233, swap=1 -> out_data=0x332211; swap=0 same cycle-later -> 0x112233; count unchanged.
REQ-035 Fill 3 words, assert rst one cycle with in_valid=out_ready=1 -> count=0, out_valid=0 after edge; next push 0xAABBCC returns 0xAABBCC first.
REQ-036 Random in_valid/out_ready (50%) with scoreboard, 10000 words, CH=4 DW=10 DEPTH=8 -> zero mismatches, count never > 8, never underflows.
